cgol_frame_capture: RTL and testbench

CGOL_FRAME_CAPTURE -- requirements
Module: cgol_frame_capture

---
 rtl/cgol_frame_capture.sv | 166 ++++++++++++++++
 tb/tb_cgol_frame_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cgol_frame_capture.sv
// Rebuilds the row-multiplexed cgol scan (one-hot row, pattern col) into complete 8x8 board frames.
// Optional still-life flag: define CGOL_CAP_STILL_DETECT_EN to add the still output.
module cgol_frame_capture #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic [7:0]  row,
    input  logic [7:0]  col,
    output logic [63:0] frame,
    output logic        frame_valid,
    output logic [6:0]  pop,
    output logic [15:0] gen_count,
    output logic        sync_err,
    output logic [7:0]  err_count
`ifdef CGOL_CAP_STILL_DETECT_EN
   ,output logic        still
`endif
);
    typedef enum logic {ST_SYNC, ST_CAPTURE} state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  exp_q, exp_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [63:0] shadow_q, shadow_d;
    logic [63:0] frame_q, frame_d;
    logic [6:0]  pop_q, pop_d;
    logic [15:0] gen_q, gen_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic [7:0]  errc_q, errc_d;
`ifdef CGOL_CAP_STILL_DETECT_EN
    logic        still_q, still_d;
`endif

    logic [2:0]  dwell_idx;
    logic [7:0]  row_exp, row_dwell;
    logic        stall, viol;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    // exp==0 means all eight rows are held, so the dwell row wraps to row 7.
    assign dwell_idx = exp_q - 3'd1;
    assign row_exp   = 8'd1 << exp_q;
    assign row_dwell = 8'd1 << dwell_idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        exp_d    = exp_q;
        tcnt_d   = tcnt_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        pop_d    = pop_q;
        gen_d    = gen_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        errc_d   = errc_q;
        stall    = 1'b0;
        viol     = 1'b0;
`ifdef CGOL_CAP_STILL_DETECT_EN
        still_d  = 1'b0;
`endif
        case (state_q)
            ST_SYNC: begin
                if (row == 8'h01) begin
                    shadow_d      = '0;
                    shadow_d[7:0] = col;
                    exp_d         = 3'd1;
                    tcnt_d        = '0;
                    state_d       = ST_CAPTURE;
                end
            end
            default: begin
                if (row == 8'h00) begin
                    stall = 1'b1;
                end else if (row == row_dwell) begin
                    shadow_d[{dwell_idx, 3'b000} +: 8] = col;
                    stall = 1'b1;
                end else if (row == row_exp && exp_q != 3'd0) begin
                    shadow_d[{exp_q, 3'b000} +: 8] = col;
                    exp_d  = exp_q + 3'd1;
                    tcnt_d = '0;
                end else if (row == 8'h01 && exp_q == 3'd0) begin
                    frame_d       = shadow_q;
                    pop_d         = popcount64(shadow_q);
                    gen_d         = gen_q + 16'd1;
                    fv_d          = 1'b1;
`ifdef CGOL_CAP_STILL_DETECT_EN
                    still_d       = (shadow_q == frame_q) && (gen_q != 16'd0);
`endif
                    shadow_d[7:0] = col;
                    exp_d         = 3'd1;
                    tcnt_d        = '0;
                end else begin
                    viol = 1'b1;
                end

                if (stall) begin
                    if (tcnt_q == TIMEOUT_LAST) viol = 1'b1;
                    else tcnt_d = tcnt_q + 8'd1;
                end

                // Any violation drops the partial frame and waits for a fresh row 0.
                if (viol) begin
                    err_d    = 1'b1;
                    errc_d   = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
                    state_d  = ST_SYNC;
                    exp_d    = '0;
                    tcnt_d   = '0;
                    shadow_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (!reset) begin
            state_q  <= ST_SYNC;
            exp_q    <= '0;
            tcnt_q   <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            pop_q    <= '0;
            gen_q    <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            errc_q   <= '0;
`ifdef CGOL_CAP_STILL_DETECT_EN
            still_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            tcnt_q   <= tcnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            pop_q    <= pop_d;
            gen_q    <= gen_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            errc_q   <= errc_d;
`ifdef CGOL_CAP_STILL_DETECT_EN
            still_q  <= still_d;
`endif
        end
    end

    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign pop         = pop_q;
    assign gen_count   = gen_q;
    assign sync_err    = err_q;
    assign err_count   = errc_q;
`ifdef CGOL_CAP_STILL_DETECT_EN
    assign still       = still_q;
`endif

endmodule

// File: tb/tb_cgol_frame_capture.sv
// Self-checking bench for cgol_frame_capture: directed scenarios plus randomized scans against a row-list model.
// Still-flag checks are compiled in when CGOL_CAP_STILL_DETECT_EN is defined.
module tb_cgol_frame_capture;
    localparam int TIMEOUT = 255;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  row = 8'h00;
    logic [7:0]  col = 8'h00;
    logic [63:0] frame;
    logic        frame_valid;
    logic [6:0]  pop;
    logic [15:0] gen_count;
    logic        sync_err;
    logic [7:0]  err_count;
`ifdef CGOL_CAP_STILL_DETECT_EN
    logic        still;
`endif

    cgol_frame_capture #(.TIMEOUT(TIMEOUT)) dut (
        .ph1         (ph1),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .frame       (frame),
        .frame_valid (frame_valid),
        .pop         (pop),
        .gen_count   (gen_count),
        .sync_err    (sync_err),
        .err_count   (err_count)
`ifdef CGOL_CAP_STILL_DETECT_EN
       ,.still       (still)
`endif
    );

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: the board is a list of captured rows; m_n counts how many are held.
    bit          m_cap;
    int          m_n;
    int          m_idle;
    logic [7:0]  m_rows [8];
    logic [63:0] m_frame;
    int          m_pop;
    int          m_gen;
    bit          m_fv;
    bit          m_err;
    int          m_errc;
    bit          m_still;

    always @(posedge ph1) begin : model_b
        logic [7:0]  r, c;
        logic [63:0] pk;
        int          ri;
        bit          stall, viol;
        r = row;
        c = col;
        m_fv = 1'b0;
        m_err = 1'b0;
        m_still = 1'b0;
        if (!reset) begin
            m_cap = 1'b0; m_n = 0; m_idle = 0;
            for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
            m_frame = '0; m_pop = 0; m_gen = 0; m_errc = 0;
        end else if (!m_cap) begin
            if (r == 8'h01) begin
                for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
                m_rows[0] = c; m_n = 1; m_idle = 0; m_cap = 1'b1;
            end
        end else begin
            ri = -1;
            for (int i = 0; i < 8; i++) if (r == 8'(1 << i)) ri = i;
            stall = 1'b0;
            viol = 1'b0;
            if (r == 8'h00) begin
                stall = 1'b1;
            end else if (ri == m_n - 1) begin
                m_rows[ri] = c; stall = 1'b1;
            end else if (ri == m_n) begin
                m_rows[ri] = c; m_n++; m_idle = 0;
            end else if (m_n == 8 && ri == 0) begin
                for (int i = 0; i < 8; i++) pk[8*i +: 8] = m_rows[i];
                m_still = (pk == m_frame) && (m_gen != 0);
                m_frame = pk;
                m_pop = $countones(pk);
                m_gen = (m_gen + 1) % 65536;
                m_fv = 1'b1;
                m_rows[0] = c; m_n = 1; m_idle = 0;
            end else begin
                viol = 1'b1;
            end
            if (stall) begin
                m_idle++;
                if (m_idle >= TIMEOUT) viol = 1'b1;
            end
            if (viol) begin
                m_err = 1'b1;
                if (m_errc < 255) m_errc++;
                m_cap = 1'b0; m_n = 0; m_idle = 0;
            end
        end
    end

    always @(negedge ph1) begin
        if (chk_en) begin
            check("frame", frame, m_frame);
            check("pop", 64'(pop), 64'(m_pop));
            check("gen_count", 64'(gen_count), 64'(m_gen));
            check("frame_valid", 64'(frame_valid), 64'(m_fv));
            check("sync_err", 64'(sync_err), 64'(m_err));
            check("err_count", 64'(err_count), 64'(m_errc));
`ifdef CGOL_CAP_STILL_DETECT_EN
            check("still", 64'(still), 64'(m_still));
`endif
        end
    end

    task automatic step(input logic [7:0] r, input logic [7:0] c, input logic rst_n = 1'b1);
        row = r;
        col = c;
        reset = rst_n;
        @(posedge ph1);
        #1;
    endtask

    task automatic scan(input logic [63:0] b, input int dwell, input int blank);
        for (int r = 0; r < 8; r++) begin
            for (int d = 0; d < dwell; d++) step(8'(1 << r), b[8*r +: 8]);
            for (int k = 0; k < blank; k++) step(8'h00, 8'h00);
        end
    endtask

    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BOARD3 = 64'h8142_2418_1824_4281;
    localparam logic [63:0] BLOCK  = 64'h0000_0018_1800_0000;

    initial begin : stim
        logic [63:0] board;
        int unsigned a;

        step(8'h00, 8'h00, 1'b0);
        chk_en = 1'b1;
        step(8'h00, 8'h00, 1'b0);
        check("rst_frame", frame, 64'h0);
        check("rst_gen", 64'(gen_count), 64'h0);
        check("rst_errc", 64'(err_count), 64'h0);

        // All-ones board, single-cycle rows.
        scan(ONES, 1, 0);
        step(8'h01, 8'h00);
        check("s1_fv", 64'(frame_valid), 64'h1);
        check("s1_frame", frame, ONES);
        check("s1_pop", 64'(pop), 64'd64);
        check("s1_gen", 64'(gen_count), 64'd1);
        check("s1_errc", 64'(err_count), 64'd0);
        step(8'h00, 8'h00);
        check("s1_fv_pulse", 64'(frame_valid), 64'h0);

        // Glider with dwell and blanking between rows.
        scan(GLIDER, 3, 2);
        step(8'h01, 8'h00);
        check("s2_frame", frame, GLIDER);
        check("s2_pop", 64'(pop), 64'd5);
        check("s2_errc", 64'(err_count), 64'd0);

        // Skipped row mid-frame.
        step(8'h01, 8'h00);
        step(8'h02, 8'h00);
        step(8'h08, 8'h00);
        check("s3_err", 64'(sync_err), 64'h1);
        check("s3_errc", 64'(err_count), 64'd1);
        check("s3_frame_kept", frame, GLIDER);
        scan(BOARD3, 1, 1);
        step(8'h01, 8'h00);
        check("s3_recover", frame, BOARD3);
        check("s3_gen", 64'(gen_count), 64'd3);

        // Non-one-hot row, then blanking timeout.
        step(8'h03, 8'h00);
        check("s4_err", 64'(sync_err), 64'h1);
        check("s4_errc", 64'(err_count), 64'd2);
        step(8'h01, 8'h11);
        step(8'h02, 8'h22);
        step(8'h04, 8'h44);
        repeat (254) step(8'h00, 8'h00);
        check("s4_no_to_yet", 64'(sync_err), 64'h0);
        step(8'h00, 8'h00);
        check("s4_timeout", 64'(sync_err), 64'h1);
        check("s4_errc2", 64'(err_count), 64'd3);

        // Reset on the completing edge wins.
        scan(BOARD3, 1, 0);
        step(8'h01, 8'h55, 1'b0);
        check("s5_fv", 64'(frame_valid), 64'h0);
        check("s5_gen", 64'(gen_count), 64'h0);
        check("s5_frame", frame, 64'h0);
        check("s5_pop", 64'(pop), 64'h0);
        check("s5_errc", 64'(err_count), 64'h0);
        step(8'h00, 8'h00);

        // Two identical 2x2 block frames.
        scan(BLOCK, 1, 0);
        step(8'h01, BLOCK[7:0]);
        check("s6_pop", 64'(pop), 64'd4);
`ifdef CGOL_CAP_STILL_DETECT_EN
        check("s6_still_first", 64'(still), 64'h0);
`endif
        scan(BLOCK, 1, 0);
        step(8'h01, 8'h00);
`ifdef CGOL_CAP_STILL_DETECT_EN
        check("s6_still_second", 64'(still), 64'h1);
`endif
        check("s6_gen", 64'(gen_count), 64'd2);

        // Randomized traffic.
        board = {$urandom, $urandom};
        for (int it = 0; it < 200; it++) begin
            a = $urandom_range(0, 19);
            if (a == 0) begin
                step(8'($urandom), 8'($urandom), 1'b0);
            end else if (a <= 2) begin
                step(8'($urandom), 8'($urandom));
            end else if (a == 3) begin
                repeat ($urandom_range(250, 258)) step(8'h00, 8'h00);
            end else begin
                if ($urandom_range(0, 1) == 1) board = {$urandom, $urandom};
                scan(board, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
            end
        end
        step(8'h01, 8'h00);
        step(8'h00, 8'h00);
        @(negedge ph1);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
